lcd_data_format_adapter_state_ctl: RTL and testbench
====================================================

LCD_DATA_FORMAT_ADAPTER_STATE_CTL -- requirements
Module: lcd_data_format_adapter_state_ctl

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 1, meaning width of the channel number and of the state-RAM address.
REQ-002 SHALL have parameter PHASE_WIDTH, default 2, meaning width of the per-channel phase and of the state-RAM data.
REQ-003 SHALL have parameter PHASE_MAX, default 2, meaning last phase value before wrap (3 bytes per pixel).
REQ-004 SHALL have parameter DATA_WIDTH, default 8, meaning stream symbol width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; ports are clk and reset.
REQ-006 Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous active-high reset.
- in_data, in, DATA_WIDTH: sink data.
- in_channel, in, CHANNEL_WIDTH: sink channel.
- in_startofpacket, in, 1: first beat of packet.
- in_endofpacket, in, 1: last beat of packet.
- in_valid, in, 1: sink valid.
- in_ready, out, 1: sink ready.
- out_data, out, DATA_WIDTH: source data.
- out_channel, out, CHANNEL_WIDTH: source channel.
- out_phase, out, PHASE_WIDTH: byte position within pixel.
- out_valid, out, 1: source valid.
- out_ready, in, 1: source ready.
- st_rd_address, out, CHANNEL_WIDTH: state-RAM read address.
- st_rd_readdata, in, PHASE_WIDTH: state-RAM read data, valid 2 cycles after address.
- st_wr_address, out, CHANNEL_WIDTH: state-RAM write address.
- st_wr_writedata, out, PHASE_WIDTH: state-RAM write data.
- st_wr_write, out, 1: state-RAM write strobe.
- st_wr_waitrequest, in, 1: state RAM clearing, writes not accepted.
- state_lost, out, 1: sticky flag, a state write was dropped.

Function
REQ-007 SHALL accept a beat when in_valid && in_ready (cycle n) and drive st_rd_address = in_channel combinationally in cycle n.
REQ-008 SHALL carry the beat through a fixed 2-stage pipeline (S1 in n+1, S2 in n+2) that never stalls.
REQ-009 In S2, phase_used SHALL be 0 if sop, else st_rd_readdata.
REQ-010 In S2, next = 0 if eop or phase_used==PHASE_MAX, else phase_used+1, computed modulo 2^PHASE_WIDTH.
REQ-011 In S2, SHALL drive st_wr_write=1, st_wr_address=channel, st_wr_writedata=next, combinationally in cycle n+2.
REQ-012 SHALL rely on the state RAM's lookahead (a write in cycle n or n+1 is returned by a read issued in cycle n); SHALL provide no internal forwarding, and back-to-back same-channel beats SHALL see the correct phase.
REQ-013 SHALL push {data, channel, phase_used} into a 4-entry output FIFO at the end of cycle n+2; out_valid first asserts in cycle n+3.
REQ-014 SHALL present the FIFO head on out_*; pop on out_valid && out_ready; simultaneous push and pop SHALL keep the count unchanged.
REQ-015 in_ready SHALL equal !st_wr_waitrequest && (fifo_count + inflight) < 4, where inflight = valid beats in S1 + S2; the FIFO SHALL never overflow.
REQ-016 Full throughput: 1 beat/cycle when out_ready is held high.
REQ-017 If st_wr_waitrequest is high while an S2 beat is present: st_wr_write SHALL be 0, the beat SHALL still be pushed to the FIFO, and state_lost SHALL set and hold until reset.

Reset
REQ-018 On reset, SHALL clear S1/S2 valids, FIFO pointers and count, and state_lost; outputs SHALL be in_ready=0, out_valid=0, st_wr_write=0, out_data/out_channel/out_phase=0.
REQ-019 Reset mid-operation SHALL discard in-flight and buffered beats with no write issued in the reset cycle; after reset, in_ready SHALL rise only once st_wr_waitrequest is 0.

Structure
REQ-020 The shared package SHALL hold the FIFO depth (4), the default widths, and the phase-increment function.
REQ-021 The 4-entry FIFO SHALL be a sub-module, lcd_data_format_adapter_state_fifo; the pipeline and control logic SHALL stay in the top module.

Verification
REQ-022 Bench SHALL include a state-RAM model with 2-cycle read latency, lookahead, and 1-entry clear-on-reset with waitrequest.
REQ-023 Single channel 0, sop on beat 0, 7 consecutive beats, out_ready=1 -> out_phase 0,1,2,0,1,2,0; first out_valid 3 cycles after acceptance.
REQ-024 Beats on channel 0 (sop), 1 (sop), 0, 1, 0 back-to-back -> phases 0,0,1,1,2.
REQ-025 eop on beat with phase 1, then next beat without sop -> next beat phase 0.
REQ-026 out_ready=0, 10 beats offered -> exactly 4 accepted, in_ready low afterward, no data loss; out_ready=1 drains them in order.
REQ-027 Force st_wr_waitrequest=1 for 1 cycle while an S2 beat is present -> st_wr_write=0, beat output, state_lost=1 until reset.
REQ-028 Assert reset for 1 cycle mid-stream with 3 beats buffered -> out_valid=0 next cycle, no st_wr_write, and the first post-reset sop beat gives phase 0.

Source files
------------

// File: rtl/lcd_data_format_adapter_state_ctl_pkg.sv
// Shared constants and helpers for the LCD data-format adapter state controller:
// output FIFO depth, default widths and the per-channel phase advance rule.
package lcd_data_format_adapter_state_ctl_pkg;

  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned FIFO_PTR_WIDTH = $clog2(FIFO_DEPTH);

  localparam int          DEFAULT_CHANNEL_WIDTH = 1;
  localparam int          DEFAULT_PHASE_WIDTH   = 2;
  localparam int unsigned DEFAULT_PHASE_MAX     = 2;
  localparam int          DEFAULT_DATA_WIDTH    = 8;

  // Phase to store for the channel's next beat; the caller truncates to its phase width.
  function automatic int unsigned phase_next(input int unsigned phase_used,
                                             input logic        eop,
                                             input int unsigned phase_max);
    return (eop || phase_used == phase_max) ? 0 : phase_used + 1;
  endfunction

endpackage

// File: rtl/lcd_data_format_adapter_state_ctl_if.sv
// Stream sink/source and state-RAM signals of the adapter state controller.
// slave is the adapter side, master is the surrounding system (sources, sink, state RAM).
interface lcd_data_format_adapter_state_ctl_if
  import lcd_data_format_adapter_state_ctl_pkg::*;
#(
  parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH,
  parameter int PHASE_WIDTH   = DEFAULT_PHASE_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0]    in_data;
  logic [CHANNEL_WIDTH-1:0] in_channel;
  logic                     in_startofpacket;
  logic                     in_endofpacket;
  logic                     in_valid;
  logic                     in_ready;

  logic [DATA_WIDTH-1:0]    out_data;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic [PHASE_WIDTH-1:0]   out_phase;
  logic                     out_valid;
  logic                     out_ready;

  logic [CHANNEL_WIDTH-1:0] st_rd_address;
  logic [PHASE_WIDTH-1:0]   st_rd_readdata;
  logic [CHANNEL_WIDTH-1:0] st_wr_address;
  logic [PHASE_WIDTH-1:0]   st_wr_writedata;
  logic                     st_wr_write;
  logic                     st_wr_waitrequest;

  logic                     state_lost;

  modport slave (
    input  in_data, in_channel, in_startofpacket, in_endofpacket, in_valid,
    input  out_ready, st_rd_readdata, st_wr_waitrequest,
    output in_ready, out_data, out_channel, out_phase, out_valid,
    output st_rd_address, st_wr_address, st_wr_writedata, st_wr_write, state_lost
  );

  modport master (
    output in_data, in_channel, in_startofpacket, in_endofpacket, in_valid,
    output out_ready, st_rd_readdata, st_wr_waitrequest,
    input  in_ready, out_data, out_channel, out_phase, out_valid,
    input  st_rd_address, st_wr_address, st_wr_writedata, st_wr_write, state_lost
  );

endinterface

// File: rtl/lcd_data_format_adapter_state_fifo.sv
// Small output FIFO for the adapter; head reads as zero while empty.
// The upstream credit check guarantees push never meets a full FIFO without a pop.
module lcd_data_format_adapter_state_fifo
  import lcd_data_format_adapter_state_ctl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          head,
  output logic [FIFO_PTR_WIDTH:0]   count
);

  localparam logic [FIFO_PTR_WIDTH:0] FULL_COUNT = (FIFO_PTR_WIDTH+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0]          mem [FIFO_DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  assign out_valid = (count != '0);
  assign do_pop    = pop && out_valid;
  assign do_push   = push && ((count != FULL_COUNT) || do_pop);
  assign head      = out_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_PTR_WIDTH+1)'(1);
        2'b01:   count <= count - (FIFO_PTR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; count qualifies every entry, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_data_format_adapter_state_ctl.sv
// Tags each stream beat with its byte position within a pixel, keeping per-channel
// phase in an external state RAM through a fixed two-stage read/modify/write pipeline.
module lcd_data_format_adapter_state_ctl
  import lcd_data_format_adapter_state_ctl_pkg::*;
#(
  parameter int          CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH,
  parameter int          PHASE_WIDTH   = DEFAULT_PHASE_WIDTH,
  parameter int unsigned PHASE_MAX     = DEFAULT_PHASE_MAX,
  parameter int          DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  lcd_data_format_adapter_state_ctl_if.slave bus
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + CHANNEL_WIDTH + PHASE_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    data;
    logic [CHANNEL_WIDTH-1:0] channel;
    logic                     sop;
    logic                     eop;
  } beat_t;

  logic                    s1_valid, s2_valid;
  beat_t                   s1_beat, s2_beat;
  logic                    accept;
  logic                    room;
  logic [PHASE_WIDTH-1:0]  phase_used;
  logic [PHASE_WIDTH-1:0]  phase_nxt;
  logic [FIFO_PTR_WIDTH:0] fifo_count;
  logic                    fifo_out_valid;
  logic [ENTRY_WIDTH-1:0]  fifo_head;
  logic                    pop;
  state_lost_t_unused_guard: assert property (@(posedge clk) disable iff (reset) 1'b1);

  // Beats in flight already own a FIFO slot, so credit counts them with the stored ones.
  assign room         = (32'(fifo_count) + 32'(s1_valid) + 32'(s2_valid)) < FIFO_DEPTH;
  assign bus.in_ready = !reset && !bus.st_wr_waitrequest && room;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.st_rd_address = bus.in_channel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_beat <= '{data:    bus.in_data,
                   channel: bus.in_channel,
                   sop:     bus.in_startofpacket,
                   eop:     bus.in_endofpacket};
    end
    s2_beat <= s1_beat;
  end

  // NOTE: every always_comb output is assigned on all paths, so no latch can be inferred.
  always_comb begin
    phase_used = s2_beat.sop ? '0 : bus.st_rd_readdata;
    phase_nxt  = PHASE_WIDTH'(phase_next(32'(phase_used), s2_beat.eop, PHASE_MAX));
  end

  // The state RAM's lookahead covers same-channel hazards, so writes go out unforwarded.
  assign bus.st_wr_write     = s2_valid && !bus.st_wr_waitrequest;
  assign bus.st_wr_address   = s2_beat.channel;
  assign bus.st_wr_writedata = phase_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   bus.state_lost <= 1'b0;
    else if (s2_valid && bus.st_wr_waitrequest)  bus.state_lost <= 1'b1;
  end

  lcd_data_format_adapter_state_fifo #(
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s2_valid),
    .push_data ({s2_beat.data, s2_beat.channel, phase_used}),
    .pop       (pop),
    .out_valid (fifo_out_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign pop           = fifo_out_valid && bus.out_ready;
  assign bus.out_valid = fifo_out_valid;
  assign {bus.out_data, bus.out_channel, bus.out_phase} = fifo_head;

endmodule

// File: tb/tb_lcd_data_format_adapter_state_ctl.sv
// Bench for the adapter state controller: state-RAM model with lookahead and
// clear-on-reset, and a scoreboard of expected {data, channel, phase} outputs.
module tb_lcd_data_format_adapter_state_ctl;
  import lcd_data_format_adapter_state_ctl_pkg::*;

  localparam int CW     = 1;
  localparam int PW     = 2;
  localparam int DW     = 8;
  localparam int NUM_CH = 1 << CW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] channel;
    logic [PW-1:0] phase;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_data_format_adapter_state_ctl_if #(
    .CHANNEL_WIDTH (CW), .PHASE_WIDTH (PW), .DATA_WIDTH (DW)
  ) bus ();

  lcd_data_format_adapter_state_ctl #(
    .CHANNEL_WIDTH (CW), .PHASE_WIDTH (PW), .PHASE_MAX (2), .DATA_WIDTH (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cycle_cnt = 0;
  exp_t sb[$];
  exp_t mon_exp;

  always @(posedge clk) cycle_cnt++;

  // State RAM: two-cycle read latency, reads see writes from the issue cycle and the one after.
  logic [PW-1:0] ram [NUM_CH];
  logic [CW-1:0] rd_q1, rd_q2, clear_idx;
  logic          clearing;
  logic          force_wait = 1'b0;

  assign bus.st_rd_readdata    = ram[rd_q2];
  assign bus.st_wr_waitrequest = clearing || force_wait;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      clearing  <= 1'b1;
      clear_idx <= '0;
      rd_q1     <= '0;
      rd_q2     <= '0;
    end else begin
      rd_q1 <= bus.st_rd_address;
      rd_q2 <= rd_q1;
      if (clearing) begin
        ram[clear_idx] <= '0;
        clear_idx      <= clear_idx + CW'(1);
        if (clear_idx == CW'(NUM_CH - 1)) clearing <= 1'b0;
      end else if (bus.st_wr_write) begin
        ram[bus.st_wr_address] <= bus.st_wr_writedata;
      end
    end
  end

  // Output monitor: every handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data=%h ch=%0d phase=%0d, expected no output",
                 bus.out_data, bus.out_channel, bus.out_phase);
      end else begin
        mon_exp = sb.pop_front();
        if ({bus.out_data, bus.out_channel, bus.out_phase} !== mon_exp) begin
          n_fail++;
          $display("FAIL output_beat: got data=%h ch=%0d phase=%0d, expected data=%h ch=%0d phase=%0d",
                   bus.out_data, bus.out_channel, bus.out_phase,
                   mon_exp.data, mon_exp.channel, mon_exp.phase);
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] ch,
                      input logic sop, input logic eop, input logic [PW-1:0] ph);
    logic acc = 1'b0;
    int   waited = 0;
    bus.in_data          = d;
    bus.in_channel       = ch;
    bus.in_startofpacket = sop;
    bus.in_endofpacket   = eop;
    bus.in_valid         = 1'b1;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid         = 1'b0;
    bus.in_startofpacket = 1'b0;
    bus.in_endofpacket   = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_accept: data=%h never accepted within %0d cycles, expected acceptance", d, waited);
    end else begin
      sb.push_back(exp_t'{data: d, channel: ch, phase: ph});
    end
  endtask

  task automatic wait_drain(input string tag);
    int waited = 0;
    while ((sb.size() != 0 || bus.out_valid) && waited < 60) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_checks++;
    if (sb.size() != 0 || bus.out_valid) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats outstanding, out_valid=%b, expected 0 and 0", tag, sb.size(), bus.out_valid);
    end
  endtask

  task automatic wait_ready(input string tag);
    int waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_checks++;
    if (!(bus.in_ready === 1'b1 && bus.st_wr_waitrequest === 1'b0)) begin
      n_fail++;
      $display("FAIL %s_ready: in_ready=%b waitrequest=%b, expected 1 and 0", tag, bus.in_ready, bus.st_wr_waitrequest);
    end
  endtask

  task automatic test_reset();
    bus.in_data = '0; bus.in_channel = '0; bus.in_startofpacket = 1'b0;
    bus.in_endofpacket = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.st_wr_write, bus.state_lost} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b st_wr_write=%b state_lost=%b, expected all 0",
               bus.in_ready, bus.out_valid, bus.st_wr_write, bus.state_lost);
    end
    n_checks++;
    if ({bus.out_data, bus.out_channel, bus.out_phase} !== '0) begin
      n_fail++;
      $display("FAIL reset_out_bus: data=%h ch=%0d phase=%0d, expected all 0",
               bus.out_data, bus.out_channel, bus.out_phase);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clearing_ready: in_ready=%b while RAM clears, expected 0", bus.in_ready);
    end
    wait_ready("reset");
  endtask

  task automatic test_latency();
    send(8'hA5, 0, 1'b1, 1'b0, 2'd0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_n1: out_valid=%b, expected 0", bus.out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus.out_valid, bus.st_wr_write, bus.st_wr_address, bus.st_wr_writedata} !== {1'b0, 1'b1, 1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL latency_n2: out_valid=%b wr=%b addr=%0d wdata=%0d, expected 0 1 0 1",
               bus.out_valid, bus.st_wr_write, bus.st_wr_address, bus.st_wr_writedata);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL latency_n3: out_valid=%b, expected 1", bus.out_valid);
    end
    wait_drain("latency");
  endtask

  task automatic test_single_channel();
    logic [PW-1:0] exp_ph [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    int start = cycle_cnt;
    for (int i = 0; i < 7; i++) send(DW'(8'h10 + i), 0, (i == 0), 1'b0, exp_ph[i]);
    n_checks++;
    if (cycle_cnt - start != 7) begin
      n_fail++; $display("FAIL throughput: 7 beats took %0d cycles, expected 7", cycle_cnt - start);
    end
    wait_drain("single_channel");
  endtask

  task automatic test_interleave();
    send(8'h20, 0, 1'b1, 1'b0, 2'd0);
    send(8'h21, 1, 1'b1, 1'b0, 2'd0);
    send(8'h22, 0, 1'b0, 1'b0, 2'd1);
    send(8'h23, 1, 1'b0, 1'b0, 2'd1);
    send(8'h24, 0, 1'b0, 1'b0, 2'd2);
    wait_drain("interleave");
  endtask

  task automatic test_eop();
    send(8'h30, 0, 1'b1, 1'b0, 2'd0);
    send(8'h31, 0, 1'b0, 1'b1, 2'd1);
    send(8'h32, 0, 1'b0, 1'b0, 2'd0);
    wait_drain("eop");
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] exp_ph [10] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    int   idx = 0;
    logic acc;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.in_data          = DW'(8'h50 + idx);
      bus.in_channel       = 1'b1;
      bus.in_startofpacket = (idx == 0);
      bus.in_endofpacket   = 1'b0;
      bus.in_valid         = 1'b1;
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sb.push_back(exp_t'{data: bus.in_data, channel: 1'b1, phase: exp_ph[idx]});
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_startofpacket = 1'b0;
    n_checks++;
    if (idx != 4) begin
      n_fail++; $display("FAIL backpressure_accepted: %0d beats accepted, expected 4", idx);
    end
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data} !== {1'b0, 1'b1, 8'h50}) begin
      n_fail++;
      $display("FAIL backpressure_stall: in_ready=%b out_valid=%b out_data=%h, expected 0 1 50",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_state_lost();
    // ch0 holds phase 1 here; a dropped write leaves it at 1 for the following beat.
    send(8'h70, 0, 1'b0, 1'b0, 2'd1);
    @(posedge clk); #1;
    force_wait = 1'b1;
    #1;
    n_checks++;
    if (bus.st_wr_write !== 1'b0) begin
      n_fail++; $display("FAIL state_lost_write: st_wr_write=%b during waitrequest, expected 0", bus.st_wr_write);
    end
    @(posedge clk); #1;
    force_wait = 1'b0;
    n_checks++;
    if (bus.state_lost !== 1'b1) begin
      n_fail++; $display("FAIL state_lost_set: state_lost=%b, expected 1", bus.state_lost);
    end
    send(8'h71, 0, 1'b0, 1'b0, 2'd1);
    wait_drain("state_lost");
    n_checks++;
    if (bus.state_lost !== 1'b1) begin
      n_fail++; $display("FAIL state_lost_sticky: state_lost=%b, expected 1", bus.state_lost);
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    send(8'h80, 0, 1'b1, 1'b0, 2'd0);
    send(8'h81, 0, 1'b0, 1'b0, 2'd1);
    send(8'h82, 0, 1'b0, 1'b0, 2'd2);
    reset = 1'b1;
    sb.delete();
    #1;
    n_checks++;
    if ({bus.out_valid, bus.st_wr_write, bus.in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_assert: out_valid=%b st_wr_write=%b in_ready=%b, expected 0 0 0",
               bus.out_valid, bus.st_wr_write, bus.in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.st_wr_write, bus.state_lost} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_release: out_valid=%b st_wr_write=%b state_lost=%b, expected 0 0 0",
               bus.out_valid, bus.st_wr_write, bus.state_lost);
    end
    bus.out_ready = 1'b1;
    wait_ready("midreset");
    send(8'h90, 0, 1'b1, 1'b0, 2'd0);
    send(8'h91, 1, 1'b0, 1'b0, 2'd0);
    send(8'h92, 0, 1'b0, 1'b0, 2'd1);
    wait_drain("midreset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_single_channel();
    test_interleave();
    test_eop();
    test_backpressure();
    test_state_lost();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
